// File: rtl/iter_shifter.sv
// Iterative shift unit: one single-bit shift stage per clock until shamt is consumed.
// Optional ITER_SHIFTER_FAST_EN applies four stages per clock while at least four remain.
module iter_shifter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] work_reg;
   logic [WIDTH-1:0] work_next;
   logic [SHW-1:0]   cnt_reg;
   logic [SHW-1:0]   cnt_next;
   logic [1:0]       opr_reg;
   logic [WIDTH-1:0] result_reg;
   logic             done_reg;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] w, input logic [1:0] o);
      logic [WIDTH-1:0] r;
      r = w;
      case (o)
         2'b00:   r = {w[WIDTH-2:0], 1'b0};
         2'b01:   r = {1'b0, w[WIDTH-1:1]};
         2'b10:   r = {w[WIDTH-1], w[WIDTH-1:1]};
         default: r = {w[0], w[WIDTH-1:1]};
      endcase
      return r;
   endfunction

`ifdef ITER_SHIFTER_FAST_EN
   logic [WIDTH-1:0] chain [0:4];
   genvar gi;

   assign chain[0] = work_reg;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_step
         assign chain[gi+1] = step(chain[gi], opr_reg);
      end
   endgenerate

   // Take the four-stage path only while enough shift amount remains.
   always_comb begin
      work_next = chain[1];
      cnt_next  = cnt_reg - SHW'(1);
      if (cnt_reg >= SHW'(4)) begin
         work_next = chain[4];
         cnt_next  = cnt_reg - SHW'(4);
      end
   end
`else
   always_comb begin
      work_next = step(work_reg, opr_reg);
      cnt_next  = cnt_reg - SHW'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         work_reg   <= '0;
         cnt_reg    <= '0;
         opr_reg    <= '0;
         result_reg <= '0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  work_reg  <= a;
                  cnt_reg   <= shamt;
                  opr_reg   <= op;
                  state_reg <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt_reg == '0) begin
                  result_reg <= work_reg;
                  done_reg   <= 1'b1;
                  state_reg  <= IDLE;
               end else begin
                  work_reg <= work_next;
                  cnt_reg  <= cnt_next;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy   = (state_reg == SHIFT);
   assign done   = done_reg;
   assign result = result_reg;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: timeline reference model checked every cycle plus directed
// literal cases. Define ITER_SHIFTER_FAST_EN here too when building the fast variant.
module tb_iter_shifter;

   localparam int W = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   iter_shifter #(.WIDTH(W), .SHW(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a),
      .shamt(shamt), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v,
                                             input logic [4:0] s);
      logic [31:0] r;
      case (o)
         2'b00:   r = v << s;
         2'b01:   r = v >> s;
         2'b10:   r = $signed(v) >>> s;
         default: r = (s == 0) ? v : ((v >> s) | (v << (32 - int'(s))));
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [4:0] s);
`ifdef ITER_SHIFTER_FAST_EN
      return int'(s) / 4 + int'(s) % 4 + 1;
`else
      return int'(s) + 1;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Timeline model: an accepted request finishes lat edges later with the reference value.
   int          cyc = 0;
   int          m_end = 0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   logic [31:0] m_result = '0;
   logic [31:0] m_pending = '0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_busy   = 1'b0;
         m_done   = 1'b0;
         m_result = '0;
      end else begin
         m_done = 1'b0;
         if (m_busy && cyc == m_end) begin
            m_busy   = 1'b0;
            m_done   = 1'b1;
            m_result = m_pending;
         end else if (!m_busy && start) begin
            m_busy    = 1'b1;
            m_end     = cyc + ref_lat(shamt);
            m_pending = ref_shift(op, a, shamt);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc busy", {31'b0, busy}, {31'b0, m_busy});
         chk("cyc done", {31'b0, done}, {31'b0, m_done});
         chk("cyc result", result, m_result);
      end
   end

   // Waits up to 100 edges for done; n counts edges since the start-sampling edge.
   task automatic wait_done(input int n0, output int n);
      bit seen = 1'b0;
      n = n0;
      while (!seen && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) n = 999;
   endtask

   task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] av,
                         input logic [4:0] s, input logic [31:0] exp_r, input int exp_l);
      int n;
      op = o; a = av; shamt = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // Scramble operands while busy: they must not be re-sampled.
      a = $urandom; op = 2'($urandom); shamt = 5'($urandom);
      wait_done(0, n);
      chk({nm, " latency"}, 32'(n), 32'(exp_l));
      chk({nm, " result"}, result, exp_r);
      $display("op %s: op=%0d a=%h shamt=%0d -> result=%h latency=%0d", nm, o, av, s, result, n);
   endtask

   initial begin
      int n;
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [4:0]  rs;
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; shamt = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {31'b0, busy}, 32'd0);
      chk("reset done", {31'b0, done}, 32'd0);
      chk("reset result", result, 32'd0);
      chk_en = 1'b1;
      rst = 1'b0;
      @(posedge clk); #1;

`ifdef ITER_SHIFTER_FAST_EN
      run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 11);
      run_op("sra4",  2'b10, 32'h8000_00F0, 5'd4,  32'hF800_000F, 2);
      run_op("srl0",  2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
      run_op("ror1",  2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 2);
      run_op("ror8b2b", 2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456, 3);
`else
      run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32);
      run_op("sra4",  2'b10, 32'h8000_00F0, 5'd4,  32'hF800_000F, 5);
      run_op("srl0",  2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
      run_op("ror1",  2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 2);
      run_op("ror8b2b", 2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456, 9);
`endif

      // Start pulsed while busy is ignored.
      @(posedge clk); #1;
      op = 2'b00; a = 32'h1; shamt = 5'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      op = 2'b11; a = 32'hFFFF_FFFF; shamt = 5'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(3, n);
      chk("ignore latency", 32'(n), 32'(ref_lat(5'd10)));
      chk("ignore result", result, 32'h0000_0400);
      $display("op ignore: result=%h latency=%0d", result, n);

      // Reset mid-operation drops the request without a done pulse.
      @(posedge clk); #1;
      op = 2'b00; a = 32'h1; shamt = 5'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      chk("midrst busy", {31'b0, busy}, 32'd0);
      chk("midrst done", {31'b0, done}, 32'd0);
      chk("midrst result", result, 32'd0);
      rst = 1'b0; start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         chk("midrst no done", {31'b0, done}, 32'd0);
      end
      $display("op midrst: busy=%0d result=%h", busy, result);

      for (int i = 0; i < 300; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rs = 5'($urandom);
         if (i % 7 == 0) begin
            @(posedge clk); #1;
         end
         run_op("rand", ro, ra, rs, ref_shift(ro, ra, rs), ref_lat(rs));
      end

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
